// File: rtl/bus_pkg.sv
// Shared definitions for the bus responder slice.
// Contents:
//   BUS_BITS                 default bus data/address width
//   PHASE_ADDR / PHASE_DATA  encodings of the bus_phase input
//   SEL_ROM / SEL_RAM        encodings of the bus_sel input
//   state_t                  responder FSM states (IDLE, ARMED)
package bus_pkg;

  localparam int BUS_BITS = 8;

  localparam logic PHASE_ADDR = 1'b0;
  localparam logic PHASE_DATA = 1'b1;

  localparam logic SEL_ROM = 1'b0;
  localparam logic SEL_RAM = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port-per-direction memory: one synchronous write port and one
// registered read port.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset; clears only the read register,
//          never the array contents
//   we     write enable; waddr/wdata are written on the posedge
//   re     read enable; rdata loads mem[raddr] on the posedge and holds
//          its value while re is low
module mem_array #(
  parameter int AW   = 8,
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [BITS-1:0] wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [BITS-1:0] rdata
);

  logic [BITS-1:0] mem [2**AW];

  // Contents are deliberately left out of the reset domain so that they
  // survive a reset of the bus logic.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/bus_responder.sv
// Memory-side responder for the CPU's shared 8-bit bus.
// An address phase latches an address and a ROM/RAM select; subsequent data
// phases read or write the selected memory with auto-increment. Read data is
// returned one cycle after the read phase.
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   bus_valid         CPU drives a bus phase this cycle
//   bus_phase         0 = address phase, 1 = data phase
//   bus_sel           0 = ROM, 1 = RAM (address phase only)
//   bus_we            data phase direction: 1 = write, 0 = read
//   bus_in            address or write data
//   bus_out           registered read data (holds last value)
//   bus_out_valid     bus_out carries fresh read data this cycle
//   bus_err           one-cycle pulse after an illegal transaction
//   prog_en/addr/data side-band ROM load; blocks the bus while high
//   dbg_state         current FSM state
//   dbg_addr          current held address register
//
// Handshake: there is no back-pressure. Every cycle with bus_valid=1 is
// consumed; its result (bus_out_valid or bus_err) appears exactly one cycle
// later and lasts one cycle.
module bus_responder
  import bus_pkg::*;
#(
  parameter int BITS   = BUS_BITS,
  parameter int ROM_AW = 8,
  parameter int RAM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_valid,
  input  logic              bus_phase,
  input  logic              bus_sel,
  input  logic              bus_we,
  input  logic [BITS-1:0]   bus_in,
  output logic [BITS-1:0]   bus_out,
  output logic              bus_out_valid,
  output logic              bus_err,
  input  logic              prog_en,
  input  logic [ROM_AW-1:0] prog_addr,
  input  logic [BITS-1:0]   prog_data,
  output state_t            dbg_state,
  output logic [BITS-1:0]   dbg_addr
);

  state_t          state, state_next;
  logic [BITS-1:0] addr_reg, addr_next;
  logic            sel_reg, sel_next;
  logic            rom_re, ram_re, ram_we;
  logic            err_next;
  logic            out_sel;
  logic [BITS-1:0] rom_rdata, ram_rdata;

  // Increment that wraps within the depth of the selected memory; bits at
  // and above aw are cleared so the address stays inside that memory.
  function automatic logic [BITS-1:0] wrap_inc(input logic [BITS-1:0] a,
                                               input int aw);
    logic [BITS-1:0] n;
    n = a + BITS'(1);
    for (int i = 0; i < BITS; i++) begin
      if (i >= aw) n[i] = 1'b0;
    end
    return n;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      addr_reg      <= '0;
      sel_reg       <= SEL_ROM;
      bus_out_valid <= 1'b0;
      bus_err       <= 1'b0;
      out_sel       <= SEL_ROM;
    end else begin
      state         <= state_next;
      addr_reg      <= addr_next;
      sel_reg       <= sel_next;
      bus_out_valid <= rom_re | ram_re;
      bus_err       <= err_next;
      // Remember which memory produced the latest read so bus_out keeps
      // showing that word until the next read.
      if (rom_re | ram_re) begin
        out_sel <= ram_re;
      end
    end
  end

  always_comb begin
    state_next = state;
    addr_next  = addr_reg;
    sel_next   = sel_reg;
    rom_re     = 1'b0;
    ram_re     = 1'b0;
    ram_we     = 1'b0;
    err_next   = 1'b0;

    if (prog_en) begin
      // ROM loading owns the memories; the CPU must stay off the bus.
      state_next = IDLE;
      err_next   = bus_valid;
    end else if (bus_valid) begin
      if (bus_phase == PHASE_ADDR) begin
        addr_next  = bus_in;
        sel_next   = bus_sel;
        state_next = ARMED;
      end else if (state == IDLE) begin
        err_next = 1'b1;
      end else if (!bus_we) begin
        if (sel_reg == SEL_RAM) begin
          ram_re    = 1'b1;
          addr_next = wrap_inc(addr_reg, RAM_AW);
        end else begin
          rom_re    = 1'b1;
          addr_next = wrap_inc(addr_reg, ROM_AW);
        end
      end else if (sel_reg == SEL_RAM) begin
        ram_we    = 1'b1;
        addr_next = wrap_inc(addr_reg, RAM_AW);
      end else begin
        // Write to ROM over the bus: refused, address held.
        err_next = 1'b1;
      end
    end
  end

  mem_array #(.AW(ROM_AW), .BITS(BITS)) u_rom (
    .clk   (clk),
    .reset (reset),
    .we    (prog_en),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (rom_re),
    .raddr (addr_reg[ROM_AW-1:0]),
    .rdata (rom_rdata)
  );

  mem_array #(.AW(RAM_AW), .BITS(BITS)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (addr_reg[RAM_AW-1:0]),
    .wdata (bus_in),
    .re    (ram_re),
    .raddr (addr_reg[RAM_AW-1:0]),
    .rdata (ram_rdata)
  );

  // Both read registers clear on reset, so bus_out reads 0 after reset
  // regardless of out_sel.
  assign bus_out   = (out_sel == SEL_RAM) ? ram_rdata : rom_rdata;
  assign dbg_state = state;
  assign dbg_addr  = addr_reg;

endmodule

// File: tb/tb_bus_responder.sv
module tb_bus_responder;
  import bus_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       bus_valid = 1'b0;
  logic       bus_phase = 1'b0;
  logic       bus_sel = 1'b0;
  logic       bus_we = 1'b0;
  logic [7:0] bus_in = 8'h00;
  logic [7:0] bus_out;
  logic       bus_out_valid;
  logic       bus_err;
  logic       prog_en = 1'b0;
  logic [7:0] prog_addr = 8'h00;
  logic [7:0] prog_data = 8'h00;
  state_t     dbg_state;
  logic [7:0] dbg_addr;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bus_responder #(.BITS(8), .ROM_AW(8), .RAM_AW(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus_valid     (bus_valid),
    .bus_phase     (bus_phase),
    .bus_sel       (bus_sel),
    .bus_we        (bus_we),
    .bus_in        (bus_in),
    .bus_out       (bus_out),
    .bus_out_valid (bus_out_valid),
    .bus_err       (bus_err),
    .prog_en       (prog_en),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .dbg_state     (dbg_state),
    .dbg_addr      (dbg_addr)
  );

  // ---------------- driver tasks ----------------
  // Each drives one cycle, then returns 1 time unit after the posedge so the
  // caller samples that cycle's registered result.
  task automatic drive(input logic v, input logic ph, input logic sel,
                       input logic we, input logic [7:0] d);
    bus_valid = v;
    bus_phase = ph;
    bus_sel   = sel;
    bus_we    = we;
    bus_in    = d;
    @(posedge clk);
    #1;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
  endtask

  task automatic do_addr(input logic sel, input logic [7:0] a);
    drive(1'b1, PHASE_ADDR, sel, 1'b0, a);
  endtask

  task automatic do_read();
    drive(1'b1, PHASE_DATA, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_write(input logic [7:0] d);
    drive(1'b1, PHASE_DATA, 1'b0, 1'b1, d);
  endtask

  task automatic do_idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_prog(input logic [7:0] a, input logic [7:0] d);
    prog_en   = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(posedge clk);
    #1;
    prog_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    total++; if (bus_out !== 8'h00) $display("FAIL reset_bus_out: got %h exp 00", bus_out); else passed++;
    total++; if (bus_out_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", bus_out_valid); else passed++;
    total++; if (bus_err !== 1'b0) $display("FAIL reset_err: got %b exp 0", bus_err); else passed++;
    total++; if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d exp 0", dbg_state); else passed++;
    total++; if (dbg_addr !== 8'h00) $display("FAIL reset_addr: got %h exp 00", dbg_addr); else passed++;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_idle_data_err();
    do_read();
    total++; if (bus_err !== 1'b1) $display("FAIL idle_data_err: got %b exp 1", bus_err); else passed++;
    total++; if (bus_out_valid !== 1'b0) $display("FAIL idle_data_valid: got %b exp 0", bus_out_valid); else passed++;
    total++; if (bus_out !== 8'h00) $display("FAIL idle_data_out: got %h exp 00", bus_out); else passed++;
    do_idle();
    total++; if (bus_err !== 1'b0) $display("FAIL idle_err_pulse: got %b exp 0", bus_err); else passed++;
  endtask

  task automatic test_rom_stream();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    for (int i = 0; i < 3; i++) do_prog(8'(i), exp_d[i]);
    do_addr(SEL_ROM, 8'h00);
    total++; if (dbg_state !== ARMED) $display("FAIL rom_armed: got %0d exp 1", dbg_state); else passed++;
    for (int i = 0; i < 3; i++) begin
      do_read();
      total++; if (bus_out_valid !== 1'b1) $display("FAIL rom_stream_valid%0d: got %b exp 1", i, bus_out_valid); else passed++;
      total++; if (bus_out !== exp_d[i]) $display("FAIL rom_stream_data%0d: got %h exp %h", i, bus_out, exp_d[i]); else passed++;
    end
    total++; if (dbg_addr !== 8'h03) $display("FAIL rom_stream_addr: got %h exp 03", dbg_addr); else passed++;
    do_idle();
    total++; if (bus_out_valid !== 1'b0) $display("FAIL rom_valid_drop: got %b exp 0", bus_out_valid); else passed++;
    total++; if (bus_out !== 8'h33) $display("FAIL rom_out_hold: got %h exp 33", bus_out); else passed++;
  endtask

  task automatic test_ram_roundtrip();
    int errs = 0;
    do_addr(SEL_RAM, 8'h10);
    do_write(8'hAB);
    errs += int'(bus_err);
    total++; if (bus_out_valid !== 1'b0) $display("FAIL ram_write_valid: got %b exp 0", bus_out_valid); else passed++;
    do_write(8'hCD);
    errs += int'(bus_err);
    total++; if (dbg_addr !== 8'h12) $display("FAIL ram_write_addr: got %h exp 12", dbg_addr); else passed++;
    do_addr(SEL_RAM, 8'h10);
    errs += int'(bus_err);
    do_read();
    errs += int'(bus_err);
    total++; if (bus_out !== 8'hAB || bus_out_valid !== 1'b1) $display("FAIL ram_rd0: got %h/%b exp ab/1", bus_out, bus_out_valid); else passed++;
    do_read();
    errs += int'(bus_err);
    total++; if (bus_out !== 8'hCD || bus_out_valid !== 1'b1) $display("FAIL ram_rd1: got %h/%b exp cd/1", bus_out, bus_out_valid); else passed++;
    total++; if (errs !== 0) $display("FAIL ram_no_err: got %0d err cycles exp 0", errs); else passed++;
  endtask

  task automatic test_rom_write_illegal();
    do_prog(8'h05, 8'h5A);
    do_addr(SEL_ROM, 8'h05);
    do_write(8'hFF);
    total++; if (bus_err !== 1'b1) $display("FAIL rom_wr_err: got %b exp 1", bus_err); else passed++;
    total++; if (dbg_addr !== 8'h05) $display("FAIL rom_wr_addr: got %h exp 05", dbg_addr); else passed++;
    do_idle();
    total++; if (bus_err !== 1'b0) $display("FAIL rom_wr_err_pulse: got %b exp 0", bus_err); else passed++;
    do_read();
    total++; if (bus_out !== 8'h5A || bus_out_valid !== 1'b1) $display("FAIL rom_wr_readback: got %h/%b exp 5a/1", bus_out, bus_out_valid); else passed++;
  endtask

  task automatic test_wrap();
    do_addr(SEL_RAM, 8'hFF);
    do_write(8'h01);
    total++; if (dbg_addr !== 8'h00) $display("FAIL wrap_addr0: got %h exp 00", dbg_addr); else passed++;
    do_write(8'h02);
    total++; if (dbg_addr !== 8'h01) $display("FAIL wrap_addr1: got %h exp 01", dbg_addr); else passed++;
    do_addr(SEL_RAM, 8'hFF);
    do_read();
    total++; if (bus_out !== 8'h01) $display("FAIL wrap_rd_ff: got %h exp 01", bus_out); else passed++;
    do_read();
    total++; if (bus_out !== 8'h02) $display("FAIL wrap_rd_00: got %h exp 02", bus_out); else passed++;
  endtask

  task automatic test_prog_conflict();
    do_addr(SEL_RAM, 8'h20);
    prog_en   = 1'b1;
    prog_addr = 8'h07;
    prog_data = 8'h77;
    do_read();
    prog_en = 1'b0;
    total++; if (bus_err !== 1'b1) $display("FAIL prog_conflict_err: got %b exp 1", bus_err); else passed++;
    total++; if (bus_out_valid !== 1'b0) $display("FAIL prog_conflict_valid: got %b exp 0", bus_out_valid); else passed++;
    total++; if (dbg_state !== IDLE) $display("FAIL prog_conflict_state: got %0d exp 0", dbg_state); else passed++;
    do_addr(SEL_ROM, 8'h07);
    do_read();
    total++; if (bus_out !== 8'h77) $display("FAIL prog_conflict_load: got %h exp 77", bus_out); else passed++;
  endtask

  task automatic test_reset_mid();
    do_addr(SEL_RAM, 8'h10);
    do_read();
    total++; if (bus_out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b exp 1", bus_out_valid); else passed++;
    reset = 1'b0;
    #1;
    total++; if (bus_out_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b exp 0", bus_out_valid); else passed++;
    total++; if (bus_out !== 8'h00) $display("FAIL mid_reset_out: got %h exp 00", bus_out); else passed++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    do_read();
    total++; if (bus_err !== 1'b1) $display("FAIL mid_idle_err: got %b exp 1", bus_err); else passed++;
    do_addr(SEL_RAM, 8'h10);
    do_read();
    total++; if (bus_out !== 8'hAB) $display("FAIL mid_ram_kept0: got %h exp ab", bus_out); else passed++;
    do_read();
    total++; if (bus_out !== 8'hCD) $display("FAIL mid_ram_kept1: got %h exp cd", bus_out); else passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_idle_data_err();
    test_rom_stream();
    test_ram_roundtrip();
    test_rom_write_illegal();
    test_wrap();
    test_prog_conflict();
    test_reset_mid();
    do_idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Memory-side responder for the CPU's shared 8-bit bus: the other end of the CPU's data_out, rom_ram and addr_data signals.
- Latches an address phase, then serves read and write data phases against an internal ROM and RAM.
- Returns read data on a registered bus with one-cycle latency.
- Includes a side-band port for loading the ROM while the CPU is held off the bus.

Parameters:
- BITS, 8, data and address width on the bus.
- ROM_AW, 8, ROM address bits; ROM depth = 2**ROM_AW.
- RAM_AW, 8, RAM address bits; RAM depth = 2**RAM_AW.

Ports:
- clk  in  1  system clock; all state updates on the posedge.
- reset  in  1  asynchronous, active-low reset.
- bus_valid  in  1  the CPU drives a bus phase this cycle.
- bus_phase  in  1  0 = address phase, 1 = data phase (CPU addr_data).
- bus_sel  in  1  0 = ROM, 1 = RAM (CPU rom_ram); sampled in the address phase only.
- bus_we  in  1  data phase: 1 = write, 0 = read.
- bus_in  in  BITS  address (address phase) or write data (data phase), from CPU data_out.
- bus_out  out  BITS  read data to CPU data_in.
- bus_out_valid  out  1  bus_out carries fresh read data this cycle.
- bus_err  out  1  one-cycle pulse on an illegal transaction.
- prog_en  in  1  ROM load enable.
- prog_addr  in  ROM_AW  ROM load address.
- prog_data  in  BITS  ROM load data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, addr_reg=0, sel_reg=0, bus_out=0, bus_out_valid=0, bus_err=0.
  - ROM and RAM contents are not cleared and survive reset.
- States: IDLE (no address held) and ARMED (addr_reg/sel_reg valid).
- Address phase (bus_valid=1, bus_phase=0), in any state:
  - addr_reg<=bus_in, sel_reg<=bus_sel, next state ARMED.
  - A new address phase in ARMED replaces the held address.
- Read data phase in ARMED (bus_valid=1, bus_phase=1, bus_we=0):
  - Next cycle: bus_out = mem[sel_reg][addr_reg low bits], bus_out_valid=1 for exactly that cycle.
  - addr_reg <= addr_reg+1, wrapping modulo the selected depth.
  - Back-to-back read phases stream one word per cycle.
- Write data phase in ARMED (bus_we=1):
  - sel_reg=RAM: RAM[addr_reg]<=bus_in, addr_reg increments with wrap, no bus_out_valid.
  - sel_reg=ROM: no write, no increment, bus_err=1 next cycle for one cycle.
- Data phase in IDLE: ignored, bus_err=1 next cycle, bus_out_valid stays 0.
- bus_valid=0: no state change; bus_out_valid=0, bus_err=0; bus_out holds its last value.
- prog_en=1:
  - ROM[prog_addr]<=prog_data every cycle; state forced to IDLE.
  - Any bus_valid=1 in the same cycle is ignored and raises bus_err next cycle.
- Address bits above ROM_AW/RAM_AW are dropped: index = low bits only.
- Reset asserted mid-stream: bus_out_valid and bus_err drop immediately (asynchronous); a pending read result is discarded.
- Arithmetic: addr_reg is BITS wide; increment is modulo 2**(ROM_AW or RAM_AW) according to sel_reg.

Decomposition:
- Shared package bus_pkg holds:
  - PHASE_ADDR=0, PHASE_DATA=1.
  - SEL_ROM=0, SEL_RAM=1.
  - State encodings IDLE=0, ARMED=1.
  - BITS default.
- One sub-module, mem_array (parameters AW, BITS):
  - Synchronous write port, registered read port.
  - Instantiated twice: ROM with the write port driven by prog_*, RAM with the write port driven by bus writes.
- bus_responder holds the FSM, addr_reg and the output mux.

Test Plan:
- ROM stream: prog ROM[0..2]=0x11,0x22,0x33; address 0x00, sel ROM; 3 read phases -> bus_out 0x11,0x22,0x33 with valid=1 on cycles +1..+3; addr_reg=0x03.
- RAM round-trip: address 0x10, sel RAM; write 0xAB then 0xCD; address 0x10 again; 2 reads -> 0xAB, 0xCD, bus_err never asserted.
- ROM write illegal: ROM[5]=0x5A; address 0x05, sel ROM; write 0xFF -> bus_err pulse of 1 cycle; following read returns 0x5A.
- Wrap: RAM address 0xFF; write 0x01, 0x02 -> RAM[0xFF]=0x01, RAM[0x00]=0x02 on readback.
- Data phase in IDLE right after reset release -> bus_err=1 for 1 cycle, bus_out_valid=0, bus_out=0x00.
- Reset mid-read: reset low in the cycle after a read phase -> bus_out_valid=0 and bus_out=0 immediately; after release, a data phase errors (IDLE); RAM contents preserved.
